// File: rtl/emergency_button_encoder.sv
// emergency_button_encoder: debounces the dashboard buttons, clear and shock inputs, priority-encodes
// button presses into the BE code and stretches shock events into a fixed-length SE pulse.
module emergency_button_encoder #(
    parameter int DB_CYCLES = 3,
    parameter int SE_HOLD   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] BTN,
    input  logic       CLR,
    input  logic       GOLPE,
    output logic [2:0] BE,
    output logic       SE,
    output logic       VALID
);
    localparam logic IDLE   = 1'b0;
    localparam logic ACTIVE = 1'b1;
    logic [6:0] raw, db_q, db_d, dbd_q, rise_q;
    logic [7:0] cnt_q [7];
    logic [7:0] cnt_d [7];
    logic [7:0] secnt_q, secnt_d;
    logic [4:0] rb;
    logic [2:0] be_q, be_d, code;
    logic       state_q, state_d, valid_q, valid_d, se_q;
    // channel order: BTN[4:0], then CLR at 5, GOLPE at 6
    assign raw = {GOLPE, CLR, BTN};
    assign rb  = rise_q[4:0];
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < 7; i++) begin
            cnt_d[i] = '0;
            if (raw[i] != db_q[i]) begin
                if (cnt_q[i] == 8'(DB_CYCLES - 1)) db_d[i] = raw[i];
                else cnt_d[i] = cnt_q[i] + 8'd1;
            end
        end
    end
    always_comb begin
        code    = rb[0] ? 3'd1 : rb[1] ? 3'd2 : rb[2] ? 3'd3 : rb[3] ? 3'd4 : 3'd5;
        be_d    = rise_q[5] ? 3'd0 : (|rb) ? code : be_q;
        state_d = rise_q[5] ? IDLE : (|rb) ? ACTIVE : state_q;
        valid_d = rise_q[5] | (|rb);
        secnt_d = rise_q[6] ? 8'(SE_HOLD) : (secnt_q != 8'd0) ? secnt_q - 8'd1 : secnt_q;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            db_q    <= '0;
            dbd_q   <= '0;
            rise_q  <= '0;
            cnt_q   <= '{default: '0};
            secnt_q <= '0;
            se_q    <= 1'b0;
            be_q    <= '0;
            state_q <= IDLE;
            valid_q <= 1'b0;
        end else begin
            db_q    <= db_d;
            dbd_q   <= db_q;
            rise_q  <= db_q & ~dbd_q;
            cnt_q   <= cnt_d;
            secnt_q <= secnt_d;
            se_q    <= secnt_d != 8'd0;
            be_q    <= be_d;
            state_q <= state_d;
            valid_q <= valid_d;
        end
    end
    assign BE    = (state_q == ACTIVE) ? be_q : 3'd0;
    assign SE    = se_q;
    assign VALID = valid_q;
endmodule
